// File: rtl/arduino_adc_motor_pwm.sv
// Avalon-MM multi-channel motor PWM driver: slew-limited duty per channel and a
// ramp-down / dead-time / flip sequence whenever the requested direction changes.
module arduino_adc_motor_pwm #(
    parameter int NUM_CH       = 2,
    parameter int PWM_W        = 8,
    parameter int DEAD_PERIODS = 4,
    parameter int ADDR_W       = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [NUM_CH-1:0] pwm_out,
    output logic [NUM_CH-1:0] dir_out,
    output logic [NUM_CH-1:0] busy
);
    typedef enum logic [1:0] {ST_RUN, ST_DOWN, ST_DEAD} state_t;

    localparam int                DEAD_W    = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;
    localparam logic [PWM_W-1:0]  CNT_MAX   = PWM_W'((1 << PWM_W) - 2);
    localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_PERIODS - 1);

    logic              enable;
    logic              brake;
    logic [15:0]       prescale;
    logic [15:0]       presc_cnt;
    logic [PWM_W-1:0]  pwm_cnt;
    logic              tick;
    logic              period_end;
    logic              wr_en;

    logic [PWM_W-1:0]  duty_tgt  [NUM_CH];
    logic [NUM_CH-1:0] dir_tgt;
    logic [PWM_W-1:0]  duty_cur  [NUM_CH];
    logic [PWM_W-1:0]  duty_next [NUM_CH];
    logic [NUM_CH-1:0] dir_cur;
    logic [NUM_CH-1:0] dir_next;
    logic [DEAD_W-1:0] dead_cnt  [NUM_CH];
    logic [DEAD_W-1:0] dead_next [NUM_CH];
    state_t            state     [NUM_CH];
    state_t            state_next[NUM_CH];

    logic unused_wdata;
    assign unused_wdata = ^writedata[31:16];

    assign wr_en = chipselect && !write_n;

    // Register file: control, prescale and per-channel targets.
    always_ff @(posedge clk) begin
        if (reset) begin
            enable   <= 1'b0;
            brake    <= 1'b0;
            prescale <= '0;
            dir_tgt  <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                duty_tgt[k] <= '0;
            end
        end else if (wr_en) begin
            if (address == ADDR_W'(0)) begin
                {brake, enable} <= writedata[1:0];
            end
            if (address == ADDR_W'(1)) begin
                prescale <= writedata[15:0];
            end
            for (int k = 0; k < NUM_CH; k++) begin
                if (address == ADDR_W'(k + 2)) begin
                    duty_tgt[k] <= writedata[PWM_W-1:0];
                    dir_tgt[k]  <= writedata[PWM_W];
                end
            end
        end
    end

    // >= rather than == so lowering PRESCALE below the running count ticks at once.
    assign tick       = enable && (presc_cnt >= prescale);
    assign period_end = tick && (pwm_cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            presc_cnt <= '0;
            pwm_cnt   <= '0;
        end else begin
            presc_cnt <= tick ? 16'd0 : presc_cnt + 16'd1;
            if (tick) begin
                pwm_cnt <= (pwm_cnt == CNT_MAX) ? '0 : pwm_cnt + PWM_W'(1);
            end
        end
    end

    // Channel FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            dir_cur <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                state[k]    <= ST_RUN;
                duty_cur[k] <= '0;
                dead_cnt[k] <= '0;
            end
        end else begin
            dir_cur <= dir_next;
            for (int k = 0; k < NUM_CH; k++) begin
                state[k]    <= state_next[k];
                duty_cur[k] <= duty_next[k];
                dead_cnt[k] <= dead_next[k];
            end
        end
    end

    // Channel FSM next-state logic.
    always_comb begin
        // NOTE: every output gets a hold default first so no path infers a latch.
        dir_next = dir_cur;
        for (int k = 0; k < NUM_CH; k++) begin
            state_next[k] = state[k];
            duty_next[k]  = duty_cur[k];
            dead_next[k]  = dead_cnt[k];
            if (!enable) begin
                state_next[k] = ST_RUN;
                duty_next[k]  = '0;
                dead_next[k]  = '0;
                dir_next[k]   = dir_tgt[k];
            end else begin
                if (period_end) begin
                    unique case (state[k])
                        ST_RUN: begin
                            if (dir_tgt[k] != dir_cur[k]) begin
                                state_next[k] = ST_DOWN;
                            end else if (duty_cur[k] < duty_tgt[k]) begin
                                duty_next[k] = duty_cur[k] + PWM_W'(1);
                            end else if (duty_cur[k] > duty_tgt[k]) begin
                                duty_next[k] = duty_cur[k] - PWM_W'(1);
                            end
                        end
                        ST_DOWN: begin
                            if (duty_cur[k] != '0) begin
                                duty_next[k] = duty_cur[k] - PWM_W'(1);
                            end else begin
                                state_next[k] = ST_DEAD;
                                dead_next[k]  = DEAD_LOAD;
                            end
                        end
                        ST_DEAD: begin
                            if (dead_cnt[k] == '0) begin
                                dir_next[k]   = dir_tgt[k];
                                state_next[k] = ST_RUN;
                            end else begin
                                dead_next[k] = dead_cnt[k] - DEAD_W'(1);
                            end
                        end
                        default: state_next[k] = ST_RUN;
                    endcase
                end
                if (brake) begin
                    duty_next[k] = '0;
                end
            end
        end
    end

    // Channel FSM outputs.
    always_comb begin
        busy = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            busy[k] = (state[k] != ST_RUN) || (duty_cur[k] != duty_tgt[k]);
        end
    end

    // Pin outputs trail the counter and dir_cur by one clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_out <= '0;
            dir_out <= '0;
        end else begin
            dir_out <= dir_cur;
            for (int k = 0; k < NUM_CH; k++) begin
                pwm_out[k] <= enable && !brake && (pwm_cnt < duty_cur[k]);
            end
        end
    end

    always_comb begin
        readdata = '0;
        if (address == ADDR_W'(0)) begin
            readdata[1:0] = {brake, enable};
        end
        if (address == ADDR_W'(1)) begin
            readdata[15:0] = prescale;
        end
        for (int k = 0; k < NUM_CH; k++) begin
            if (address == ADDR_W'(k + 2)) begin
                readdata[PWM_W:0]     = {dir_tgt[k], duty_tgt[k]};
                readdata[16 +: PWM_W] = duty_cur[k];
                readdata[31]          = dir_cur[k];
            end
        end
    end

endmodule

// File: tb/tb_arduino_adc_motor_pwm.sv
// Directed bench for arduino_adc_motor_pwm (PWM_W=4, DEAD_PERIODS=2): channel 1 runs
// at duty 1 so its single-clock pulse marks each period boundary.
module tb_arduino_adc_motor_pwm;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [1:0]  pwm_out;
    logic [1:0]  dir_out;
    logic [1:0]  busy;

    int tests_run = 0;
    int tests_failed = 0;
    int viol = 0;
    logic mon_dir = 1'b0;
    logic mon_pwm = 1'b0;

    arduino_adc_motor_pwm #(
        .NUM_CH(2), .PWM_W(4), .DEAD_PERIODS(2), .ADDR_W(4)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .pwm_out(pwm_out), .dir_out(dir_out), .busy(busy)
    );

    always #10 clk = ~clk;

    // Flags any dir_out change while channel 0 PWM is high around it.
    always @(negedge clk) begin
        if (dir_out[0] !== mon_dir && (pwm_out[0] === 1'b1 || mon_pwm === 1'b1)) viol++;
        mon_dir = dir_out[0];
        mon_pwm = pwm_out[0];
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        #1;
        d = readdata;
        chipselect = 1'b0;
    endtask

    // Returns just after the clock on which pwm_out[1] rises, i.e. one clock after a period end.
    task automatic wait_pe(output int clks);
        logic prev;
        bit found;
        prev = pwm_out[1];
        found = 0;
        clks = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk);
            #1;
            clks++;
            if (!prev && pwm_out[1]) found = 1;
            prev = pwm_out[1];
        end
        if (!found) begin
            tests_run++; tests_failed++;
            $display("FAIL wait_pe: no period marker within %0d clk", clks);
        end
    endtask

    task automatic count_high(input int ch, input int n, output int highs);
        highs = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (pwm_out[ch]) highs++;
        end
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        reset = 1'b1;
        wait_clks(2);
        reset = 1'b0;
        wait_clks(1);
        for (int a = 0; a < 4; a++) begin
            bus_read(4'(a), rd);
            tests_run++;
            if (rd !== 32'h0) begin
                tests_failed++;
                $display("FAIL reset_read addr %0d: got %h expected %h", a, rd, 32'h0);
            end
        end
        tests_run++;
        if ({pwm_out, dir_out, busy} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got pwm=%b dir=%b busy=%b expected all 0", pwm_out, dir_out, busy);
        end
    endtask

    task automatic test_ramp_up;
        logic [31:0] rd;
        int highs;
        bus_write(4'd3, 32'h01);
        bus_write(4'd2, 32'h03);
        tests_run++;
        if (busy !== 2'b11) begin
            tests_failed++;
            $display("FAIL ramp_busy_idle: got %b expected %b", busy, 2'b11);
        end
        bus_write(4'd0, 32'h1);
        wait_clks(14);
        bus_read(4'd2, rd);
        tests_run++;
        if (rd !== 32'h0000_0003) begin
            tests_failed++;
            $display("FAIL ramp_before_pe: got %h expected %h", rd, 32'h0000_0003);
        end
        for (int i = 1; i <= 3; i++) begin
            wait_clks(i == 1 ? 1 : 15);
            bus_read(4'd2, rd);
            tests_run++;
            if (rd !== ((32'(i) << 16) | 32'h3)) begin
                tests_failed++;
                $display("FAIL ramp_step %0d: got %h expected %h", i, rd, (32'(i) << 16) | 32'h3);
            end
            tests_run++;
            if (busy[0] !== (i != 3)) begin
                tests_failed++;
                $display("FAIL ramp_busy %0d: got %b expected %b", i, busy[0], (i != 3));
            end
        end
        count_high(0, 15, highs);
        tests_run++;
        if (highs != 3) begin
            tests_failed++;
            $display("FAIL ramp_duty_3of15: got %0d expected %0d", highs, 3);
        end
        bus_read(4'd3, rd);
        tests_run++;
        if (rd !== 32'h0001_0001) begin
            tests_failed++;
            $display("FAIL ramp_ch1_read: got %h expected %h", rd, 32'h0001_0001);
        end
    endtask

    task automatic test_reversal;
        int c;
        logic [31:0] rd;
        logic [31:0] exp;
        int exp_duty [8] = '{2, 1, 0, 0, 0, 0, 1, 2};
        int exp_dir  [8] = '{0, 0, 0, 0, 0, 1, 1, 1};
        int exp_busy [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
        wait_pe(c);
        bus_write(4'd2, 32'h02);
        wait_pe(c);
        bus_read(4'd2, rd);
        tests_run++;
        if (rd !== 32'h0002_0002) begin
            tests_failed++;
            $display("FAIL rev_start: got %h expected %h", rd, 32'h0002_0002);
        end
        viol = 0;
        bus_write(4'd2, 32'h12);
        for (int i = 0; i < 8; i++) begin
            wait_pe(c);
            bus_read(4'd2, rd);
            exp = (32'(exp_dir[i]) << 31) | (32'(exp_duty[i]) << 16) | 32'h12;
            tests_run++;
            if (rd !== exp) begin
                tests_failed++;
                $display("FAIL rev_step %0d: got %h expected %h", i + 1, rd, exp);
            end
            tests_run++;
            if (dir_out[0] !== 1'(exp_dir[i]) || busy[0] !== 1'(exp_busy[i])) begin
                tests_failed++;
                $display("FAIL rev_pins %0d: got dir=%b busy=%b expected dir=%0d busy=%0d",
                         i + 1, dir_out[0], busy[0], exp_dir[i], exp_busy[i]);
            end
        end
        tests_run++;
        if (viol != 0) begin
            tests_failed++;
            $display("FAIL rev_pwm_at_flip: got %0d violations expected 0", viol);
        end
    endtask

    task automatic test_duty_full;
        int c;
        int highs;
        logic [31:0] rd;
        bus_write(4'd2, 32'h1F);
        repeat (13) wait_pe(c);
        bus_read(4'd2, rd);
        tests_run++;
        if (rd !== 32'h800F_001F) begin
            tests_failed++;
            $display("FAIL full_read: got %h expected %h", rd, 32'h800F_001F);
        end
        count_high(0, 30, highs);
        tests_run++;
        if (highs != 30) begin
            tests_failed++;
            $display("FAIL full_const_high: got %0d expected %0d", highs, 30);
        end
    endtask

    task automatic test_prescale;
        int c;
        logic [31:0] rd;
        bus_write(4'd1, 32'h2);
        bus_read(4'd1, rd);
        tests_run++;
        if (rd !== 32'h2) begin
            tests_failed++;
            $display("FAIL presc_read: got %h expected %h", rd, 32'h2);
        end
        wait_pe(c);
        wait_pe(c);
        wait_pe(c);
        tests_run++;
        if (c != 45) begin
            tests_failed++;
            $display("FAIL presc_period_45: got %0d expected %0d", c, 45);
        end
        bus_write(4'd1, 32'h0);
        wait_pe(c);
        wait_pe(c);
        wait_pe(c);
        tests_run++;
        if (c != 15) begin
            tests_failed++;
            $display("FAIL presc_period_15: got %0d expected %0d", c, 15);
        end
    endtask

    task automatic test_brake_enable;
        int c;
        int highs;
        logic [31:0] rd;
        bus_write(4'd2, 32'h15);
        repeat (10) wait_pe(c);
        bus_read(4'd2, rd);
        tests_run++;
        if (rd !== 32'h8005_0015) begin
            tests_failed++;
            $display("FAIL brake_pre: got %h expected %h", rd, 32'h8005_0015);
        end
        bus_write(4'd0, 32'h3);
        wait_clks(1);
        bus_read(4'd2, rd);
        tests_run++;
        if (pwm_out !== 2'b00 || rd !== 32'h8000_0015) begin
            tests_failed++;
            $display("FAIL brake_apply: got pwm=%b rd=%h expected pwm=00 rd=%h", pwm_out, rd, 32'h8000_0015);
        end
        count_high(0, 30, highs);
        tests_run++;
        if (highs != 0) begin
            tests_failed++;
            $display("FAIL brake_hold_low: got %0d expected %0d", highs, 0);
        end
        bus_write(4'd0, 32'h1);
        for (int i = 1; i <= 2; i++) begin
            wait_pe(c);
            bus_read(4'd2, rd);
            tests_run++;
            if (rd !== (32'h8000_0015 | (32'(i) << 16))) begin
                tests_failed++;
                $display("FAIL brake_release %0d: got %h expected %h", i, rd, 32'h8000_0015 | (32'(i) << 16));
            end
        end
        bus_write(4'd0, 32'h0);
        wait_clks(1);
        bus_read(4'd2, rd);
        tests_run++;
        if (pwm_out !== 2'b00 || rd !== 32'h8000_0015 || busy !== 2'b11) begin
            tests_failed++;
            $display("FAIL disable: got pwm=%b rd=%h busy=%b expected pwm=00 rd=%h busy=11",
                     pwm_out, rd, busy, 32'h8000_0015);
        end
        count_high(0, 40, highs);
        tests_run++;
        if (highs != 0) begin
            tests_failed++;
            $display("FAIL disable_hold_low: got %0d expected %0d", highs, 0);
        end
    endtask

    task automatic test_unmapped;
        logic [31:0] rd;
        logic [31:0] exp [6] = '{32'h0, 32'h0, 32'h8000_0015, 32'h0000_0001, 32'h0, 32'h0};
        bus_write(4'd5, 32'hFFFF_FFFF);
        bus_write(4'd15, 32'hFFFF_FFFF);
        for (int a = 0; a < 6; a++) begin
            bus_read(4'(a), rd);
            tests_run++;
            if (rd !== exp[a]) begin
                tests_failed++;
                $display("FAIL unmapped addr %0d: got %h expected %h", a, rd, exp[a]);
            end
        end
        bus_read(4'd15, rd);
        tests_run++;
        if (rd !== 32'h0) begin
            tests_failed++;
            $display("FAIL unmapped addr 15: got %h expected %h", rd, 32'h0);
        end
    endtask

    task automatic test_reset_in_dead;
        int c;
        logic [31:0] rd;
        bus_write(4'd0, 32'h1);
        bus_write(4'd2, 32'h05);
        wait_pe(c);
        wait_pe(c);
        tests_run++;
        if (busy[0] !== 1'b1 || dir_out[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL dead_entry: got busy=%b dir=%b expected busy=1 dir=1", busy[0], dir_out[0]);
        end
        reset = 1'b1;
        wait_clks(1);
        tests_run++;
        if ({pwm_out, dir_out, busy} !== 6'b0) begin
            tests_failed++;
            $display("FAIL dead_reset_pins: got pwm=%b dir=%b busy=%b expected all 0", pwm_out, dir_out, busy);
        end
        for (int a = 0; a < 3; a++) begin
            bus_read(4'(a), rd);
            tests_run++;
            if (rd !== 32'h0) begin
                tests_failed++;
                $display("FAIL dead_reset_read addr %0d: got %h expected %h", a, rd, 32'h0);
            end
        end
        reset = 1'b0;
        wait_clks(1);
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_reversal();
        test_duty_full();
        test_prescale();
        test_brake_enable();
        test_unmapped();
        test_reset_in_dead();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
